// File: rtl/spi_slave_if.sv
// Byte-level handshake and serial pins of the SPI slave.
// The slave modport is the DUT view; the master modport is the system/bench view.
interface spi_slave_if;
   logic       ss_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_underrun;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_overrun;
   logic       frame_abort;

   modport slave (
      input  ss_n, mosi, tx_data, tx_valid, rx_ack,
      output miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun, frame_abort
   );

   modport master (
      output ss_n, mosi, tx_data, tx_valid, rx_ack,
      input  miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun, frame_abort
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 style byte slave clocked directly by sclk: one load edge, eight
// sample edges and one DONE edge per byte, with a one-deep TX holding register.
module spi_slave #(
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input logic       sclk,
   input logic       rstn,
   spi_slave_if.slave bus
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          hold_valid_q, hold_valid_d;
   logic [DW-1:0] tx_shift_q, tx_shift_d;
   logic [DW-1:0] rx_shift_q, rx_shift_d;
   logic [DW-1:0] rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          underrun_q, underrun_d;
   logic          overrun_q, overrun_d;
   logic          abort_q, abort_d;
   logic          miso_q;

   // Next-state, datapath and pulse generation.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      tx_shift_d   = tx_shift_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      underrun_d   = 1'b0;
      overrun_d    = 1'b0;
      abort_d      = 1'b0;

      if (bus.tx_valid && !hold_valid_q) begin
         hold_d       = bus.tx_data;
         hold_valid_d = 1'b1;
      end

      if (bus.rx_ack) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!bus.ss_n) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               // A byte offered on this same edge is parked for the next frame.
               if (hold_valid_q) begin
                  tx_shift_d   = hold_q;
                  hold_valid_d = 1'b0;
               end else begin
                  tx_shift_d = IDLE_BYTE;
                  underrun_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (bus.ss_n) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               rx_shift_d = {rx_shift_q[DW-2:0], bus.mosi};
               bit_cnt_d  = bit_cnt_q + CW'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d    = DONE;
                  rx_data_d  = {rx_shift_q[DW-2:0], bus.mosi};
                  rx_valid_d = 1'b1;
                  overrun_d  = rx_valid_q && !bus.rx_ack;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         tx_shift_q   <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tx_shift_q   <= tx_shift_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         underrun_q   <= underrun_d;
         overrun_q    <= overrun_d;
         abort_q      <= abort_d;
      end
   end

   // miso launches half a cycle ahead so the master samples it on the next posedge.
   always_ff @(negedge sclk) begin
      if (!rstn) begin
         miso_q <= 1'b0;
      end else if (state_q == SHIFT) begin
         miso_q <= tx_shift_q[LAST_BIT - bit_cnt_q];
      end else begin
         miso_q <= 1'b0;
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = (state_q == SHIFT);
   assign bus.tx_ready    = !hold_valid_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.rx_overrun  = overrun_q;
   assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expected TX/RX bytes, a
// monitor acting as the SPI master collects miso bits and checks each completion.
module tb_spi_slave;

   logic sclk;
   logic rstn;

   spi_slave_if bus ();

   spi_slave #(.IDLE_BYTE(8'hFF)) dut (
      .sclk (sclk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   int tests;
   int fails;
   int n_under;
   int n_over;
   int n_abort;
   logic [7:0] q_tx[$];
   logic [7:0] q_rx[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle; inputs change just after the falling edge.
   task automatic step();
      @(negedge sclk);
      #1;
   endtask

   // One full 10-edge byte; ss_n is left low so the caller decides on back-to-back.
   task automatic frame(input logic [7:0] mb, input logic [7:0] exp_tx, input logic exp_ready,
                        input logic ack_last, input logic offer, input logic [7:0] offer_data);
      q_tx.push_back(exp_tx);
      q_rx.push_back(mb);
      bus.ss_n = 1'b0;
      if (offer) begin
         bus.tx_valid = 1'b1;
         bus.tx_data  = offer_data;
      end
      step();
      bus.tx_valid = 1'b0;
      check("tx_ready_after_load", 32'(bus.tx_ready), 32'(exp_ready));
      for (int i = 0; i < 8; i++) begin
         bus.mosi = mb[7-i];
         if (i == 7 && ack_last) bus.rx_ack = 1'b1;
         step();
         bus.rx_ack = 1'b0;
      end
      step();
   endtask

   task automatic preload(input logic [7:0] d);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      step();
      bus.tx_valid = 1'b0;
   endtask

   task automatic ack();
      bus.rx_ack = 1'b1;
      step();
      bus.rx_ack = 1'b0;
      check("rx_valid_after_ack", 32'(bus.rx_valid), 32'd0);
   endtask

   // Monitor: master-side sampler on each posedge plus pulse-width tracking.
   initial begin
      logic       prev_oe;
      logic       pu, po, pa;
      int         cnt;
      logic [7:0] sh_b;
      logic [7:0] e;
      prev_oe = 1'b0;
      pu = 1'b0; po = 1'b0; pa = 1'b0;
      cnt = 0;
      sh_b = '0;
      forever begin
         @(posedge sclk);
         #1;
         if (prev_oe && !bus.ss_n && rstn) begin
            sh_b = {sh_b[6:0], bus.miso};
            cnt++;
            if (cnt == 8) begin
               if (q_tx.size() == 0 || q_rx.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_byte: got miso 0x%0h rx 0x%0h, expected no byte", sh_b, bus.rx_data);
               end else begin
                  e = q_tx.pop_front();
                  check("miso_byte", 32'(sh_b), 32'(e));
                  e = q_rx.pop_front();
                  check("rx_data", 32'(bus.rx_data), 32'(e));
                  check("rx_valid_on_done", 32'(bus.rx_valid), 32'd1);
               end
               cnt = 0;
            end
         end
         if (!bus.miso_oe) cnt = 0;
         prev_oe = bus.miso_oe;
         if (bus.tx_underrun) begin check("underrun_width", 32'(pu), 32'd0); n_under++; end
         if (bus.rx_overrun)  begin check("overrun_width",  32'(po), 32'd0); n_over++;  end
         if (bus.frame_abort) begin check("abort_width",    32'(pa), 32'd0); n_abort++; end
         pu = bus.tx_underrun;
         po = bus.rx_overrun;
         pa = bus.frame_abort;
      end
   end

   initial begin
      int u0, o0, a0;
      tests = 0; fails = 0;
      n_under = 0; n_over = 0; n_abort = 0;
      rstn = 1'b0;
      bus.ss_n = 1'b1;
      bus.mosi = 1'b0;
      bus.tx_data = '0;
      bus.tx_valid = 1'b0;
      bus.rx_ack = 1'b0;
      step();
      step();
      check("rst_miso", 32'(bus.miso), 32'd0);
      check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
      check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_pulses", 32'({bus.tx_underrun, bus.rx_overrun, bus.frame_abort}), 32'd0);
      rstn = 1'b1;
      step();

      // Preloaded A5 out, 3C in.
      preload(8'hA5);
      check("tx_ready_after_accept", 32'(bus.tx_ready), 32'd0);
      u0 = n_under;
      frame(8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      check("no_underrun_preloaded", 32'(n_under - u0), 32'd0);
      check("rx_data_3c", 32'(bus.rx_data), 32'h3C);
      ack();

      // Empty hold: IDLE_BYTE out with one underrun pulse.
      u0 = n_under;
      frame(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      check("underrun_once", 32'(n_under - u0), 32'd1);
      ack();

      // Back-to-back without ack: second completion overruns.
      o0 = n_over;
      frame(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      frame(8'h22, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      check("overrun_once", 32'(n_over - o0), 32'd1);
      check("rx_data_22", 32'(bus.rx_data), 32'h22);
      check("rx_valid_22", 32'(bus.rx_valid), 32'd1);
      ack();

      // Abort after four samples keeps the previous byte.
      frame(8'h77, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      a0 = n_abort;
      bus.ss_n = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         bus.mosi = i[0];
         step();
      end
      bus.ss_n = 1'b1;
      step();
      check("abort_once", 32'(n_abort - a0), 32'd1);
      check("abort_miso_oe", 32'(bus.miso_oe), 32'd0);
      check("abort_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("abort_rx_data", 32'(bus.rx_data), 32'h77);
      ack();
      frame(8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      check("rx_data_5a", 32'(bus.rx_data), 32'h5A);
      ack();

      // Ack on the completion edge of the second byte: no overrun.
      o0 = n_over;
      frame(8'h33, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
      frame(8'h44, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      check("ack_race_no_overrun", 32'(n_over - o0), 32'd0);
      check("ack_race_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("ack_race_rx_data", 32'(bus.rx_data), 32'h44);
      ack();

      // Byte offered on the load edge goes to the next frame, not this one.
      u0 = n_under;
      frame(8'hC4, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h96);
      bus.ss_n = 1'b1;
      step();
      check("load_offer_underrun", 32'(n_under - u0), 32'd1);
      ack();
      frame(8'h0F, 8'h96, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      ack();

      // Reset in the middle of a frame.
      bus.ss_n = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         bus.mosi = 1'b1;
         step();
      end
      u0 = n_under; o0 = n_over; a0 = n_abort;
      rstn = 1'b0;
      bus.ss_n = 1'b1;
      step();
      rstn = 1'b1;
      check("mid_rst_miso", 32'(bus.miso), 32'd0);
      check("mid_rst_miso_oe", 32'(bus.miso_oe), 32'd0);
      check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("mid_rst_rx_data", 32'(bus.rx_data), 32'd0);
      step();
      check("mid_rst_no_pulses", 32'((n_under - u0) + (n_over - o0) + (n_abort - a0)), 32'd0);
      preload(8'hC3);
      frame(8'hE7, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
      bus.ss_n = 1'b1;
      step();
      step();

      check("q_tx_drained", 32'(q_tx.size()), 32'd0);
      check("q_rx_drained", 32'(q_rx.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: IDLE_BYTE, 8'hFF, byte shifted out on miso when no TX byte is held at frame start.
REQ-002 sclk  in  1  sole clock; free-running; all logic on posedge except the miso flop (negedge).
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 ss_n  in  1  slave select, active-low; high = deselected.
REQ-005 mosi  in  1  serial data from master, MSB first, sampled on posedge.
REQ-006 miso  out 1  serial data to master, MSB first, updated on negedge.
REQ-007 miso_oe  out 1  miso output enable; 1 exactly while state is SHIFT.
REQ-008 tx_data  in  8  byte to transmit.
REQ-009 tx_valid  in  1  tx_data offered this cycle.
REQ-010 tx_ready  out 1  holding register empty; equals !hold_valid.
REQ-011 tx_underrun  out 1  one-cycle pulse: frame started with empty holding register.
REQ-012 rx_data  out 8  last received byte.
REQ-013 rx_valid  out 1  rx_data unread; level, held until rx_ack.
REQ-014 rx_ack  in  1  consumer has read rx_data.
REQ-015 rx_overrun  out 1  one-cycle pulse: byte completed while previous byte unread.
REQ-016 frame_abort  out 1  one-cycle pulse: ss_n deasserted mid-byte.

Function
REQ-017 States SHALL be IDLE, SHIFT, DONE; 3-bit bit_cnt counts samples taken in SHIFT.
REQ-018 IDLE: posedge with ss_n=0 is the load edge -> SHIFT, bit_cnt=0; no mosi sample on this edge.
REQ-019 Load edge: tx_shift <= hold if hold_valid (hold_valid cleared), else tx_shift <= IDLE_BYTE and tx_underrun pulses.
REQ-020 SHIFT, ss_n=0: sample mosi into rx_shift (shift left, LSB in), bit_cnt+1; 8th sample -> DONE.
REQ-021 8th sample edge SHALL write rx_data <= {rx_shift[6:0], mosi} and set rx_valid; data visible next cycle.
REQ-022 SHIFT, ss_n=1: -> IDLE, no sample, partial byte discarded, rx_data/rx_valid unchanged, frame_abort pulses.
REQ-023 DONE -> IDLE unconditionally; ss_n and mosi ignored; a byte costs 10 posedges (load, 8 samples, DONE).
REQ-024 ss_n held low through DONE SHALL start the next byte at the following IDLE edge (back-to-back).
REQ-025 miso negedge flop: SHIFT -> tx_shift[7-bit_cnt]; otherwise 0; so bit 7 is valid before the first sample edge.
REQ-026 TX accept: posedge with tx_valid=1 and tx_ready=1 -> hold <= tx_data, hold_valid <= 1.
REQ-027 tx_valid=1 on the load edge with empty hold: byte captured into hold for the next frame, IDLE_BYTE sent this frame, tx_underrun pulses (no bypass).
REQ-028 rx_ack=1 clears rx_valid; rx_ack with rx_valid=0 has no effect.
REQ-029 Completion while rx_valid=1 and rx_ack=0: rx_data overwritten, rx_valid stays 1, rx_overrun pulses.
REQ-030 Completion and rx_ack on the same edge: new byte kept, rx_valid=1, no overrun.
REQ-031 Pulse outputs SHALL be high for exactly one sclk cycle per event.

Reset
REQ-032 rstn=0 at posedge: state IDLE, bit_cnt 0, hold_valid 0, tx_shift 0, rx_shift 0, rx_data 8'h00, rx_valid 0, all pulses 0.
REQ-033 rstn=0 at negedge: miso 0; miso_oe 0 from the first reset posedge.
REQ-034 Reset mid-SHIFT SHALL discard the frame with no rx_valid, frame_abort, or underrun pulse.

Verification
REQ-035 Preload tx 8'hA5, ss_n low 10 edges, mosi 8'h3C -> miso 1,0,1,0,0,1,0,1; rx_data 8'h3C, rx_valid 1; tx_ready 1 after load edge.
REQ-036 No preload, frame with mosi 8'h01 -> miso 8'hFF, tx_underrun one pulse on load edge, rx_data 8'h01.
REQ-037 Two back-to-back bytes (ss_n low 20 edges), no rx_ack, mosi 8'h11 then 8'h22 -> rx_data 8'h22, rx_valid 1, rx_overrun one pulse at 2nd completion.
REQ-038 ss_n high after 4 samples -> frame_abort pulse, IDLE, rx_valid/rx_data unchanged; next full frame 8'h5A received correctly.
REQ-039 rx_ack asserted on the completion edge of byte 2 -> rx_valid 1, rx_data byte 2, no overrun.
REQ-040 rstn low for 1 edge during bit 5 -> all outputs at reset values; next frame with preload 8'hC3 sends 8'hC3.
